// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative 1-bit/cycle shifter,
// feeding a one-entry registered EX/MEM output with a valid/ready handshake.
module ex_alu_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);

    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlXor = 4'b0011;
    localparam logic [3:0] CtlSrl = 4'b0100;
    localparam logic [3:0] CtlLui = 4'b0101;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSlt = 4'b0111;
    localparam logic [3:0] CtlSll = 4'b1000;
    localparam logic [3:0] CtlNor = 4'b1010;
    localparam logic [3:0] CtlSra = 4'b1100;

    typedef enum logic {StIdle, StShift} state_e;
    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shkind_e;

    state_e             state_q, state_d;
    shkind_e            kind_q, kind_d, in_kind;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_shifted;
    logic [4:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]   stag_q, stag_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf, alu_ill, is_shift, out_free;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input shkind_e k);
        case (k)
            ShSrl:   shift1 = {1'b0, v[WIDTH-1:1]};
            ShSra:   shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift1 = {v[WIDTH-2:0], 1'b0};
        endcase
    endfunction

    assign sum         = op_a + op_b;
    assign diff        = op_a - op_b;
    assign out_free    = !out_valid_q || out_ready;
    assign in_ready    = (state_q == StIdle) && out_free;
    assign acc_shifted = shift1(acc_q, kind_q);

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        in_kind  = ShSll;
        case (alu_ctrl)
            CtlAdd: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtlSub: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtlAnd: alu_res = op_a & op_b;
            CtlOr:  alu_res = op_a | op_b;
            CtlXor: alu_res = op_a ^ op_b;
            CtlNor: alu_res = ~(op_a | op_b);
            CtlSlt: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            CtlLui: alu_res = op_b << 16;
            // Shift by zero completes immediately with the operand unchanged.
            CtlSll: begin alu_res = op_b; is_shift = 1'b1; in_kind = ShSll; end
            CtlSrl: begin alu_res = op_b; is_shift = 1'b1; in_kind = ShSrl; end
            CtlSra: begin alu_res = op_b; is_shift = 1'b1; in_kind = ShSra; end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        stag_d      = stag_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        tag_out_d   = tag_out_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        if (is_shift && shamt != 5'd0) begin
                            acc_d   = op_b;
                            cnt_d   = shamt;
                            kind_d  = in_kind;
                            stag_d  = tag_in;
                            state_d = StShift;
                        end else begin
                            out_valid_d = 1'b1;
                            result_d    = alu_res;
                            zero_d      = (alu_res == '0);
                            ovf_d       = alu_ovf;
                            illegal_d   = alu_ill;
                            tag_out_d   = tag_in;
                        end
                    end
                end
                StShift: begin
                    if (cnt_q != 5'd1) begin
                        acc_d = acc_shifted;
                        cnt_d = cnt_q - 5'd1;
                    end else if (out_free) begin
                        // Final step goes straight into the output register.
                        out_valid_d = 1'b1;
                        result_d    = acc_shifted;
                        zero_d      = (acc_shifted == '0);
                        ovf_d       = 1'b0;
                        illegal_d   = 1'b0;
                        tag_out_d   = stag_q;
                        cnt_d       = '0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            kind_q      <= ShSll;
            stag_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            tag_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            stag_q      <= stag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            tag_out_q   <= tag_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: driver pushes reference results, a monitor pops on handshake.
module tb_ex_alu_stage;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, ovf, illegal;
    logic [4:0]  tag_out;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_bp = 1'b0;
    exp_t sb[$];
    int   accq[$];
    int   latq[$];

    ex_alu_stage #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .shamt(shamt), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .ovf(ovf), .illegal(illegal), .tag_out(tag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: plain arithmetic on the control-code table.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, input logic [4:0] t);
        exp_t e;
        longint sa, sbv, r;
        logic signed [31:0] bs;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        bs = b;
        r = 0;
        e = '0;
        e.tag = t;
        case (c)
            4'b0010: begin r = sa + sbv; e.res = r[31:0];
                           e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'b0110: begin r = sa - sbv; e.res = r[31:0];
                           e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b1010: e.res = ~(a | b);
            4'b0111: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            4'b0101: e.res = b << 16;
            4'b1000: e.res = b << sh;
            4'b0100: e.res = b >> sh;
            4'b1100: e.res = bs >>> sh;
            default: begin e.res = '0; e.il = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one entry and hold it until accepted; lat<0 means latency is not checked.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] t, input int lat);
        bit ok;
        ok = 1'b0;
        alu_ctrl = c; op_a = a; op_b = b; shamt = sh; tag_in = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            sb.push_back(model(c, a, b, sh, t));
            accq.push_back(cyc);
            latq.push_back(lat);
            @(posedge clk);
            #1;
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries outstanding, required 0", sb.size());
            sb.delete(); accq.delete(); latq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got result=%h tag=%0d, required no output",
                         result, tag_out);
            end else begin
                exp_t e;
                int   ac, l;
                e  = sb.pop_front();
                ac = accq.pop_front();
                l  = latq.pop_front();
                if ({result, zero, ovf, illegal, tag_out} !== e) begin
                    n_fail++;
                    $display("FAIL entry: got res=%h z=%b o=%b il=%b tag=%0d, required res=%h z=%b o=%b il=%b tag=%0d",
                             result, zero, ovf, illegal, tag_out, e.res, e.z, e.o, e.il, e.tag);
                end
                if (l >= 0) begin
                    n_cmp++;
                    if (cyc - ac != l) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - ac, l);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] codes [12];
        codes = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'hA, 4'h7, 4'h5, 4'h8, 4'h4, 4'hC, 4'hF};

        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zero, ovf, illegal}, 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3, 1);
        send(4'b0110, 32'h0000_1234, 32'h0000_1234, 5'd0, 5'd4, 1);
        send(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5, 1);
        send(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 5'd9, 1);
        send(4'b1000, 32'd0, 32'hCAFE_0001, 5'd0, 5'd6, 1);

        send(4'b1100, 32'd0, 32'h8000_0010, 5'd4, 5'd7, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sra_in_ready_busy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("sra_in_ready_done", 32'(in_ready), 32'd1);
        drain();

        out_ready = 1'b0;
        fork
            begin
                send(4'b0010, 32'd100, 32'd1, 5'd0, 5'd1, -1);
                send(4'b0010, 32'd200, 32'd2, 5'd0, 5'd2, -1);
                send(4'b0010, 32'd300, 32'd3, 5'd0, 5'd3, -1);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_held_result", result, 32'd101);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(4'b1000, 32'd0, 32'h0000_0001, 5'd31, 5'd12, -1);
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb.delete(); accq.delete(); latq.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(4'b0101, 32'd0, 32'h0000_ABCD, 5'd0, 5'd13, 1);
        repeat (40) @(posedge clk);
        #1;
        drain();

        send(4'b1100, 32'd0, 32'h8000_0000, 5'd20, 5'd11, -1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", {29'd0, zero, ovf, illegal}, 32'd0);
        chk("arst_tag", 32'(tag_out), 32'd0);
        sb.delete(); accq.delete(); latq.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            logic [4:0] sh;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 11)];
            sh = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            send(c, $urandom, $urandom, sh, 5'($urandom), -1);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU of the multistage pipeline. It sits directly downstream of the ALU control decoder and consumes its 4-bit ALU control code together with the two operands and the shift amount from ID/EX. It computes the result and drives a registered EX/MEM output with a valid/ready handshake. Shifts run on an iterative 1-bit-per-cycle shifter, so the stage can stall upstream.

## Interface
Parameters:
- WIDTH, 32, datapath width; shifts and LUI assume 32.
- TAG_W, 5, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill: drops the output entry and aborts any shift in progress.
- in_valid  input  1  ID/EX entry present.
- in_ready  output  1  stage can accept this cycle (combinational).
- alu_ctrl  input  4  code from the ALU control decoder.
- op_a  input  WIDTH  rs operand.
- op_b  input  WIDTH  rt or immediate operand.
- shamt  input  5  shift amount.
- tag_in  input  TAG_W  destination register.
- out_valid  output  1  result register holds a valid entry.
- out_ready  input  1  EX/MEM consumer accepts.
- result  output  WIDTH  registered result.
- zero  output  1  registered, result==0.
- ovf  output  1  registered signed overflow (add/sub only, else 0).
- illegal  output  1  registered, alu_ctrl not in the decoded set.
- tag_out  output  TAG_W  registered tag.

## Operation
- Control codes: 0010 add A+B; 0110 sub A−B; 0000 and; 0001 or; 0011 xor; 1010 nor; 0111 slt (signed A<B → 1, else 0); 0101 lui (B<<16); 1000 sll B by shamt; 0100 srl B; 1100 sra B.
- Any other code gives result 0 and illegal=1, and completes as a single-cycle op.
- Arithmetic is modulo 2^WIDTH.
- ovf on add: sign(A)==sign(B) and sign(sum)!=sign(A).
- ovf on sub: sign(A)!=sign(B) and sign(diff)!=sign(A).
- ovf is a flag only; the stage never traps.
- States:
  - IDLE: accepts entries.
  - SHIFT: holds acc, cnt, op kind and tag.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready:
  - Non-shift, or shift with shamt==0: result, flags and tag are written to the output register. out_valid=1. Stay in IDLE.
  - Shift with shamt≥1: acc=op_b, cnt=shamt, go to SHIFT.
- SHIFT, each cycle:
  - If cnt>1: shift acc by one (sll fills 0; srl fills 0; sra fills acc[31]) and decrement cnt.
  - If cnt==1 and the output register is free (!out_valid || out_ready): write the once-more-shifted value, zero, ovf=0, illegal=0 and tag. Set out_valid=1. Go to IDLE.
  - If cnt==1 and the output register is not free: hold acc and cnt unchanged.
- Output register: on out_valid && out_ready with no new write, out_valid goes to 0. result and flags keep their last value.
- flush (wins over everything): out_valid=0, state=IDLE. Any accept in the same cycle is discarded.
- Reset values:
  - out_valid=0, result=0, zero=0, ovf=0, illegal=0, tag_out=0.
  - state=IDLE, cnt=0, acc=0.
  - in_ready=1 once rst_n deasserts.

## Timing
- Single-cycle ops: accept at edge T gives out_valid high after edge T (latency 1). Throughput is 1/cycle while out_ready=1.
- Shifts with shamt=n≥1: accept at edge T; shifts occur at edges T+1..T+n; out_valid rises after edge T+n. Latency is n+1. in_ready=0 during SHIFT.
- Simultaneous consume and refill: an output being consumed at the same edge as a new write is overwritten with no bubble.
- Reset asserted mid-shift: clears immediately (asynchronous). No result is produced.
- Flush mid-shift: the shift is abandoned. in_ready=1 the next cycle, provided the output register is free.

## Test plan
- Add overflow: op_a=0x7FFFFFFF, op_b=1, code 0010 → result=0x80000000, ovf=1, zero=0, 1-cycle latency.
- Sub to zero: op_a=op_b=0x1234, code 0110 → result=0, zero=1, ovf=0. Also slt with op_a=−1, op_b=1 → result=1.
- SRA shamt=4, op_b=0x80000010, tag 7:
  - out_valid is asserted 5 cycles after accept.
  - result=0xF8000001, tag_out=7.
  - in_ready=0 for 4 cycles.
- Backpressure: out_ready=0 with three back-to-back adds queued → the first stays held, in_ready=0, no entry is lost. Releasing out_ready delivers the entries in order, one per cycle.
- Flush during sll shamt=31 at the third shift cycle → no out_valid. A following lui with op_b=0xABCD is accepted the next cycle → result=0xABCD0000.
- Illegal code 1111 → result=0, illegal=1. Asserting rst_n low asynchronously mid-shift → all outputs return to 0 without a clock edge.
